// File: rtl/am29x_pkg.sv
// am29x_pkg: shared types for the am29x_slice register-file ALU.
//   src_e / func_e / dst_e : I[2:0] / I[5:3] / I[8:6] instruction fields
//   state_e                : sequencer state
//   ctrl_t                 : latched control portion of an accepted instruction
package am29x_pkg;

  localparam int unsigned DEF_WIDTH     = 16;
  localparam int unsigned DEF_REG_COUNT = 16;
  localparam int unsigned DEF_CNT_W     = 4;

  // Operand pair (R,S) selection
  typedef enum logic [2:0] {
    SRC_AQ = 3'd0, SRC_AB = 3'd1, SRC_ZQ = 3'd2, SRC_ZB = 3'd3,
    SRC_ZA = 3'd4, SRC_DA = 3'd5, SRC_DQ = 3'd6, SRC_DZ = 3'd7
  } src_e;

  typedef enum logic [2:0] {
    FN_ADD  = 3'd0, FN_SUBR = 3'd1, FN_SUBS  = 3'd2, FN_OR    = 3'd3,
    FN_AND  = 3'd4, FN_NOTRS = 3'd5, FN_EXOR = 3'd6, FN_EXNOR = 3'd7
  } func_e;

  typedef enum logic [2:0] {
    DST_QREG  = 3'd0, DST_NOP  = 3'd1, DST_RAMA  = 3'd2, DST_RAMF = 3'd3,
    DST_RAMQD = 3'd4, DST_RAMD = 3'd5, DST_RAMQU = 3'd6, DST_RAMU = 3'd7
  } dst_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  typedef struct packed {
    dst_e  dst;
    func_e fn;
    src_e  src;
    logic  cn;
    logic  ram_lsb_in;
    logic  ram_msb_in;
    logic  q_lsb_in;
    logic  q_msb_in;
  } ctrl_t;

endpackage

// File: rtl/am29x_slice_if.sv
// am29x_slice_if: instruction handshake and result bus of am29x_slice.
//   master : microsequencer side (drives instruction, receives results)
//   slave  : slice side
//   in_valid/in_ready : instruction transfer when both high
//   i, a, b, d, cn, cnt, *_in : instruction payload
//   y, cn4, ovr, f_zero, f_msb, ram_sh_out, q_sh_out, out_valid : results
interface am29x_slice_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AW    = 4,
  parameter int unsigned CNT_W = 4
);
  logic             in_valid;
  logic             in_ready;
  logic [8:0]       i;
  logic [AW-1:0]    a;
  logic [AW-1:0]    b;
  logic [WIDTH-1:0] d;
  logic             cn;
  logic [CNT_W-1:0] cnt;
  logic             ram_lsb_in;
  logic             ram_msb_in;
  logic             q_lsb_in;
  logic             q_msb_in;
  logic [WIDTH-1:0] y;
  logic             cn4;
  logic             ovr;
  logic             f_zero;
  logic             f_msb;
  logic             ram_sh_out;
  logic             q_sh_out;
  logic             out_valid;

  modport master (
    output in_valid, i, a, b, d, cn, cnt, ram_lsb_in, ram_msb_in, q_lsb_in, q_msb_in,
    input  in_ready, y, cn4, ovr, f_zero, f_msb, ram_sh_out, q_sh_out, out_valid
  );

  modport slave (
    input  in_valid, i, a, b, d, cn, cnt, ram_lsb_in, ram_msb_in, q_lsb_in, q_msb_in,
    output in_ready, y, cn4, ovr, f_zero, f_msb, ram_sh_out, q_sh_out, out_valid
  );
endinterface

// File: rtl/am29x_alu.sv
// am29x_alu: combinational operand select and function unit.
//   a_data, b_data, d, q : candidate operands
//   src, fn, cn          : source pair, function, carry in
//   f_c                  : function result
//   cn4_c, ovr_c         : carry out / signed overflow (0 for logic ops)
//   f_zero_c, f_msb_c    : F==0, F[WIDTH-1]
module am29x_alu
  import am29x_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] q,
  input  src_e             src,
  input  func_e            fn,
  input  logic             cn,
  output logic [WIDTH-1:0] f_c,
  output logic             cn4_c,
  output logic             ovr_c,
  output logic             f_zero_c,
  output logic             f_msb_c
);

  localparam int unsigned SW = WIDTH + 1;

  logic [WIDTH-1:0] r, s, op_r, op_s;
  logic [SW-1:0]    sum;

  // R/S operand selection
  always_comb begin
    r = '0;
    s = '0;
    case (src)
      SRC_AQ: begin r = a_data; s = q;      end
      SRC_AB: begin r = a_data; s = b_data; end
      SRC_ZQ: begin r = '0;     s = q;      end
      SRC_ZB: begin r = '0;     s = b_data; end
      SRC_ZA: begin r = '0;     s = a_data; end
      SRC_DA: begin r = d;      s = a_data; end
      SRC_DQ: begin r = d;      s = q;      end
      SRC_DZ: begin r = d;      s = '0;     end
    endcase
  end

  // Function unit; carry into the MSB is recovered from the sum and operand MSBs
  always_comb begin
    op_r  = (fn == FN_SUBR) ? ~r : r;
    op_s  = (fn == FN_SUBS) ? ~s : s;
    sum   = {1'b0, op_r} + {1'b0, op_s} + SW'(cn);
    f_c   = sum[WIDTH-1:0];
    cn4_c = 1'b0;
    ovr_c = 1'b0;
    case (fn)
      FN_ADD, FN_SUBR, FN_SUBS: begin
        cn4_c = sum[WIDTH];
        ovr_c = sum[WIDTH] ^ (sum[WIDTH-1] ^ op_r[WIDTH-1] ^ op_s[WIDTH-1]);
      end
      FN_OR:    f_c = r | s;
      FN_AND:   f_c = r & s;
      FN_NOTRS: f_c = ~r & s;
      FN_EXOR:  f_c = r ^ s;
      FN_EXNOR: f_c = ~(r ^ s);
    endcase
    f_zero_c = (f_c == '0);
    f_msb_c  = f_c[WIDTH-1];
  end

endmodule

// File: rtl/am29x_slice.sv
// am29x_slice: WIDTH-bit, REG_COUNT-entry register-file ALU with Q register,
// up/down shifters, valid/ready instruction intake and a repeat count.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : am29x_slice_if slave (instruction in, registered results out;
//                in_ready is combinational)
module am29x_slice
  import am29x_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned REG_COUNT = DEF_REG_COUNT,
  parameter int unsigned CNT_W     = DEF_CNT_W
) (
  input logic         clk,
  input logic         rst_n,
  am29x_slice_if.slave bus
);

  localparam int unsigned AW = $clog2(REG_COUNT);

  state_e           state_q, state_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic [AW-1:0]    a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] dat_q, dat_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] ram_q [REG_COUNT];
  logic [WIDTH-1:0] ram_d [REG_COUNT];
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic             cn4_q, cn4_d, ovr_q, ovr_d;
  logic             f_zero_q, f_zero_d, f_msb_q, f_msb_d;
  logic             ram_sh_q, ram_sh_d, q_sh_q, q_sh_d;
  logic             out_valid_q, out_valid_d;

  logic             take_c;
  logic [WIDTH-1:0] a_data_c, b_data_c, f_c;
  logic             cn4_c, ovr_c, f_zero_c, f_msb_c;

  assign bus.in_ready = (state_q == ST_IDLE) || (rem_q == '0);
  assign take_c       = bus.in_valid && bus.in_ready;
  assign a_data_c     = ram_q[a_q];
  assign b_data_c     = ram_q[b_q];

  am29x_alu #(.WIDTH(WIDTH)) u_alu (
    .a_data   (a_data_c),
    .b_data   (b_data_c),
    .d        (dat_q),
    .q        (q_q),
    .src      (ctrl_q.src),
    .fn       (ctrl_q.fn),
    .cn       (ctrl_q.cn),
    .f_c      (f_c),
    .cn4_c    (cn4_c),
    .ovr_c    (ovr_c),
    .f_zero_c (f_zero_c),
    .f_msb_c  (f_msb_c)
  );

  // Next state: execute one iteration per EXEC cycle, accept a new instruction when ready
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    a_d         = a_q;
    b_d         = b_q;
    dat_d       = dat_q;
    rem_d       = rem_q;
    ram_d       = ram_q;
    q_d         = q_q;
    y_d         = y_q;
    cn4_d       = cn4_q;
    ovr_d       = ovr_q;
    f_zero_d    = f_zero_q;
    f_msb_d     = f_msb_q;
    ram_sh_d    = ram_sh_q;
    q_sh_d      = q_sh_q;
    out_valid_d = 1'b0;

    if (state_q == ST_EXEC) begin
      y_d      = (ctrl_q.dst == DST_RAMA) ? a_data_c : f_c;
      cn4_d    = cn4_c;
      ovr_d    = ovr_c;
      f_zero_d = f_zero_c;
      f_msb_d  = f_msb_c;
      ram_sh_d = 1'b0;
      q_sh_d   = 1'b0;
      case (ctrl_q.dst)
        DST_QREG: q_d = f_c;
        DST_NOP:  ;
        DST_RAMA, DST_RAMF: ram_d[b_q] = f_c;
        DST_RAMQD: begin
          ram_d[b_q] = {ctrl_q.ram_msb_in, f_c[WIDTH-1:1]};
          q_d        = {ctrl_q.q_msb_in, q_q[WIDTH-1:1]};
          ram_sh_d   = f_c[0];
          q_sh_d     = q_q[0];
        end
        DST_RAMD: begin
          ram_d[b_q] = {ctrl_q.ram_msb_in, f_c[WIDTH-1:1]};
          ram_sh_d   = f_c[0];
        end
        DST_RAMQU: begin
          ram_d[b_q] = {f_c[WIDTH-2:0], ctrl_q.ram_lsb_in};
          q_d        = {q_q[WIDTH-2:0], ctrl_q.q_lsb_in};
          ram_sh_d   = f_c[WIDTH-1];
          q_sh_d     = q_q[WIDTH-1];
        end
        DST_RAMU: begin
          ram_d[b_q] = {f_c[WIDTH-2:0], ctrl_q.ram_lsb_in};
          ram_sh_d   = f_c[WIDTH-1];
        end
      endcase
      if (rem_q == '0) begin
        out_valid_d = 1'b1;
        state_d     = ST_IDLE;
      end else begin
        rem_d = rem_q - CNT_W'(1);
      end
    end

    // Capture overrides the IDLE fall-back after a final iteration
    if (take_c) begin
      state_d           = ST_EXEC;
      ctrl_d.dst        = dst_e'(bus.i[8:6]);
      ctrl_d.fn         = func_e'(bus.i[5:3]);
      ctrl_d.src        = src_e'(bus.i[2:0]);
      ctrl_d.cn         = bus.cn;
      ctrl_d.ram_lsb_in = bus.ram_lsb_in;
      ctrl_d.ram_msb_in = bus.ram_msb_in;
      ctrl_d.q_lsb_in   = bus.q_lsb_in;
      ctrl_d.q_msb_in   = bus.q_msb_in;
      a_d               = bus.a;
      b_d               = bus.b;
      dat_d             = bus.d;
      rem_d             = bus.cnt;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ctrl_q      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      dat_q       <= '0;
      rem_q       <= '0;
      for (int k = 0; k < REG_COUNT; k++) ram_q[k] <= '0;
      q_q         <= '0;
      y_q         <= '0;
      cn4_q       <= 1'b0;
      ovr_q       <= 1'b0;
      f_zero_q    <= 1'b0;
      f_msb_q     <= 1'b0;
      ram_sh_q    <= 1'b0;
      q_sh_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      a_q         <= a_d;
      b_q         <= b_d;
      dat_q       <= dat_d;
      rem_q       <= rem_d;
      ram_q       <= ram_d;
      q_q         <= q_d;
      y_q         <= y_d;
      cn4_q       <= cn4_d;
      ovr_q       <= ovr_d;
      f_zero_q    <= f_zero_d;
      f_msb_q     <= f_msb_d;
      ram_sh_q    <= ram_sh_d;
      q_sh_q      <= q_sh_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.y          = y_q;
  assign bus.cn4        = cn4_q;
  assign bus.ovr        = ovr_q;
  assign bus.f_zero     = f_zero_q;
  assign bus.f_msb      = f_msb_q;
  assign bus.ram_sh_out = ram_sh_q;
  assign bus.q_sh_out   = q_sh_q;
  assign bus.out_valid  = out_valid_q;

endmodule
